exec_cond_stage: RTL and testbench
==================================

# exec_cond_stage

Execute-to-memory boundary of the pipelined datapath, sitting directly downstream of the ALU. Holds the architectural condition-flag register ({Zero, Neg}), evaluates each execute-stage instruction's condition code against it, gates that instruction's side effects, and registers the ALU result plus gated control into the memory stage. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- N, default 32: datapath width, equal to ALU width.
- R, default 4: register-address width.

- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high.
- StallE  in  1: hold the execute instruction; no state change.
- FlushE  in  1: squash the execute instruction.
- ValidE  in  1: execute slot holds a real instruction.
- CondE  in  3: condition code (see Operation).
- FlagWriteE  in  1: instruction updates flags.
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE  in  1 each: ungated control.
- ALUResultE  in  N: ALU result.
- ALUFlagsE  in  2: ALU flags, {Zero, Neg}.
- WriteDataE  in  N: store data.
- RdE  in  R: destination register.
- CondExE  out  1: combinational condition-pass for the execute instruction.
- FlagsQ  out  2: flag register, {Zero, Neg}.
- ValidM, RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each: registered, gated control.
- ALUResultM, WriteDataM  out  N: registered data.
- RdM  out  R: registered destination.

## Operation
- Condition codes, evaluated on FlagsQ (Z = FlagsQ[1], N = FlagsQ[0]): 000 EQ Z; 001 NE !Z; 010 LT N; 011 GE !N; 100 GT !Z & !N; 101 LE Z | N; 110 AL 1; 111 NV 0.
- CondExE = ValidE & cond_pass(CondE, FlagsQ).
- Advance = !StallE & !FlushE.
- Flag update: on an edge with Advance & CondExE & FlagWriteE, FlagsQ <= ALUFlagsE; otherwise FlagsQ holds.
- Pipeline register, priority reset > FlushE > StallE > advance:
  - reset: every output register 0, FlagsQ = 00.
  - FlushE (takes effect even when StallE is also 1): ValidM, RegWriteM, MemWriteM, MemtoRegM and PCSrcM <= 0. Data and RdM are don't-care and are loaded as in advance. The flushed instruction never writes flags.
  - StallE & !FlushE: all M registers and FlagsQ hold.
  - advance: ValidM <= ValidE; RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE; PCSrcM <= PCSrcE & CondExE; MemtoRegM <= MemtoRegE & CondExE; ALUResultM, WriteDataM, RdM <= E-stage values.
- A failed condition produces a valid M instruction (ValidM = 1) that has all four side-effect controls at 0.
- ValidE = 0 behaves as a bubble: CondExE = 0, so all control is gated and flags are untouched.
- No arithmetic is performed here; data paths are pass-through at width N without extension or truncation.

## Timing
- CondExE: zero latency, combinational from CondE, ValidE and FlagsQ. No combinational path from ALUFlagsE.
- All M outputs and FlagsQ: one-cycle latency, updated on the rising edge.
- A flag-setting instruction at edge k is visible to the next instruction's CondExE in cycle k+1. Back-to-back set/test therefore needs no forwarding.
- A stalled instruction writes flags once, on the edge it advances. It never writes on the stalled edges.
- Reset asserted mid-stream discards the E instruction and clears FlagsQ on that same edge. The first instruction after reset sees flags 00 (EQ fails, NE passes).

## Structure
- Shared package (exec_pkg): enumerated cond_t for the eight codes, flag index constants FLAG_Z = 1 and FLAG_N = 0, and the flag-vector width 2.
- One sub-module, cond_check: combinational (cond_t, flags) -> pass.
- The top-level module contains the flag register and the M pipeline register.

## Test plan
- Reset: assert reset with random inputs -> every M output and FlagsQ are 0 next cycle; CondExE = 0 for CondE = EQ.
- Set then test: instruction 1 (AL, FlagWriteE = 1, ALUFlagsE = 10) followed by instruction 2 (EQ, RegWriteE = 1, ALUResultE = 0x0000_0005) -> FlagsQ = 10, CondExE = 1, then RegWriteM = 1 and ALUResultM = 5.
- Condition fail: FlagsQ = 00 with CondE = LT, MemWriteE = 1, FlagWriteE = 1, ALUFlagsE = 01 -> CondExE = 0, MemWriteM = 0, ValidM = 1, FlagsQ stays 00.
- Stall: hold StallE for 3 cycles on a flag-setting AL instruction -> M outputs and FlagsQ frozen for 3 cycles; the flag write lands exactly once, on release.
- Flush with stall: FlushE = StallE = 1 on an AL instruction with RegWriteE = 1 and FlagWriteE = 1 -> RegWriteM = 0, ValidM = 0, FlagsQ unchanged.
- Sweep: all 8 codes × 4 flag values -> CondExE matches the table above; NV is always 0 and AL is always 1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage condition logic.
// Defines the condition-code encoding and the flag-vector layout.
package exec_pkg;

    localparam int FLAG_W = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        COND_EQ = 3'b000,
        COND_NE = 3'b001,
        COND_LT = 3'b010,
        COND_GE = 3'b011,
        COND_GT = 3'b100,
        COND_LE = 3'b101,
        COND_AL = 3'b110,
        COND_NV = 3'b111
    } cond_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with
// condition code cond_i may take effect given the architectural flags.
module cond_check
    import exec_pkg::*;
(
    input  cond_t              cond_i,
    input  logic [FLAG_W-1:0]  flags_i,
    output logic               pass_o
);

    logic z;
    logic n;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_LT: pass_o = n;
            COND_GE: pass_o = !n;
            COND_GT: pass_o = !z && !n;
            COND_LE: pass_o = z || n;
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-to-memory boundary: owns the {Zero, Neg} flag register, gates the
// execute instruction's side effects on its condition, and registers into M.
module exec_cond_stage
    import exec_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidE,
    input  logic [2:0]        CondE,
    input  logic              FlagWriteE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemtoRegE,
    input  logic              PCSrcE,
    input  logic [N-1:0]      ALUResultE,
    input  logic [FLAG_W-1:0] ALUFlagsE,
    input  logic [N-1:0]      WriteDataE,
    input  logic [R-1:0]      RdE,
    output logic              CondExE,
    output logic [FLAG_W-1:0] FlagsQ,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemtoRegM,
    output logic              PCSrcM,
    output logic [N-1:0]      ALUResultM,
    output logic [N-1:0]      WriteDataM,
    output logic [R-1:0]      RdM
);

    logic              cond_pass;
    logic              advance;

    logic [FLAG_W-1:0] flags_q,     flags_d;
    logic              valid_q,     valid_d;
    logic              regwrite_q,  regwrite_d;
    logic              memwrite_q,  memwrite_d;
    logic              memtoreg_q,  memtoreg_d;
    logic              pcsrc_q,     pcsrc_d;
    logic [N-1:0]      result_q,    result_d;
    logic [N-1:0]      wdata_q,     wdata_d;
    logic [R-1:0]      rd_q,        rd_d;

    cond_check u_cond_check (
        .cond_i  (cond_t'(CondE)),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    // Evaluated on the registered flags only, so ALUFlagsE never reaches CondExE.
    assign CondExE = ValidE & cond_pass;
    assign advance = !StallE & !FlushE;

    always_comb begin
        flags_d    = flags_q;
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        pcsrc_d    = pcsrc_q;
        result_d   = result_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;

        if (advance && CondExE && FlagWriteE) begin
            flags_d = ALUFlagsE;
        end

        // Flush wins over stall: a squashed slot must become a bubble even when held.
        if (FlushE) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            pcsrc_d    = 1'b0;
            result_d   = ALUResultE;
            wdata_d    = WriteDataE;
            rd_d       = RdE;
        end else if (!StallE) begin
            valid_d    = ValidE;
            regwrite_d = RegWriteE & CondExE;
            memwrite_d = MemWriteE & CondExE;
            memtoreg_d = MemtoRegE & CondExE;
            pcsrc_d    = PCSrcE & CondExE;
            result_d   = ALUResultE;
            wdata_d    = WriteDataE;
            rd_d       = RdE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            pcsrc_q    <= 1'b0;
            result_q   <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            flags_q    <= flags_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            pcsrc_q    <= pcsrc_d;
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
        end
    end

    assign FlagsQ     = flags_q;
    assign ValidM     = valid_q;
    assign RegWriteM  = regwrite_q;
    assign MemWriteM  = memwrite_q;
    assign MemtoRegM  = memtoreg_q;
    assign PCSrcM     = pcsrc_q;
    assign ALUResultM = result_q;
    assign WriteDataM = wdata_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Self-checking bench for exec_cond_stage: a behavioural model pushes the
// expected M-stage state per cycle into a queue, popped after each edge.
module tb_exec_cond_stage;

    localparam int N = 32;
    localparam int R = 4;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        pcs;
        logic [31:0] res;
        logic [31:0] wd;
        logic [3:0]  rd;
        logic [1:0]  flags;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [2:0]  cond;
        logic        fw;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        pcs;
        logic [31:0] res;
        logic [1:0]  aflags;
        logic [31:0] wd;
        logic [3:0]  rd;
    } in_t;

    logic          clk;
    logic          reset;
    logic          StallE, FlushE, ValidE;
    logic [2:0]    CondE;
    logic          FlagWriteE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE;
    logic [N-1:0]  ALUResultE, WriteDataE;
    logic [1:0]    ALUFlagsE;
    logic [R-1:0]  RdE;
    logic          CondExE;
    logic [1:0]    FlagsQ;
    logic          ValidM, RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [N-1:0]  ALUResultM, WriteDataM;
    logic [R-1:0]  RdM;

    int   tests;
    int   fails;
    exp_t m;
    logic exp_cex;
    exp_t sb[$];

    exec_cond_stage #(.N(N), .R(R)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
        .ALUResultE(ALUResultE), .ALUFlagsE(ALUFlagsE), .WriteDataE(WriteDataE),
        .RdE(RdE), .CondExE(CondExE), .FlagsQ(FlagsQ), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .PCSrcM(PCSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_cond(input logic [2:0] c, input logic [1:0] f);
        logic z;
        logic n;
        z = f[1];
        n = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n;
            3'd3: return !n;
            3'd4: return !z && !n;
            3'd5: return z || n;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic in_t nop();
        in_t t;
        t.rst = 0; t.stall = 0; t.flush = 0; t.valid = 0; t.cond = 3'd0; t.fw = 0;
        t.rw = 0; t.mw = 0; t.m2r = 0; t.pcs = 0; t.res = '0; t.aflags = '0;
        t.wd = '0; t.rd = '0;
        return t;
    endfunction

    function automatic in_t rand_in();
        in_t t;
        t.rst = 0; t.stall = 0; t.flush = 0; t.valid = 1'($urandom);
        t.cond = 3'($urandom); t.fw = 1'($urandom); t.rw = 1'($urandom);
        t.mw = 1'($urandom); t.m2r = 1'($urandom); t.pcs = 1'($urandom);
        t.res = $urandom; t.aflags = 2'($urandom); t.wd = $urandom; t.rd = 4'($urandom);
        return t;
    endfunction

    function automatic exp_t sample();
        return {ValidM, RegWriteM, MemWriteM, MemtoRegM, PCSrcM,
                ALUResultM, WriteDataM, RdM, FlagsQ};
    endfunction

    // Drives one E-stage cycle just after the falling edge, updates the model,
    // and queues the M-stage state expected after the next rising edge.
    task automatic apply(input in_t t);
        logic cex;
        @(negedge clk);
        reset = t.rst; StallE = t.stall; FlushE = t.flush; ValidE = t.valid;
        CondE = t.cond; FlagWriteE = t.fw; RegWriteE = t.rw; MemWriteE = t.mw;
        MemtoRegE = t.m2r; PCSrcE = t.pcs; ALUResultE = t.res; ALUFlagsE = t.aflags;
        WriteDataE = t.wd; RdE = t.rd;
        cex = t.valid & model_cond(t.cond, m.flags);
        exp_cex = cex;
        if (t.rst) begin
            m = '0;
        end else if (t.flush) begin
            m.valid = 0; m.rw = 0; m.mw = 0; m.m2r = 0; m.pcs = 0;
            m.res = t.res; m.wd = t.wd; m.rd = t.rd;
        end else if (!t.stall) begin
            m.valid = t.valid; m.rw = t.rw & cex; m.mw = t.mw & cex;
            m.m2r = t.m2r & cex; m.pcs = t.pcs & cex;
            m.res = t.res; m.wd = t.wd; m.rd = t.rd;
            if (cex && t.fw) m.flags = t.aflags;
        end
        sb.push_back(m);
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o;
        in_t  t;
        t = rand_in();
        t.rst = 1;
        apply(t);
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || o !== '0) begin
            fails++;
            $display("FAIL reset_state got=%h want=%h", o, e);
        end
        t = nop();
        t.valid = 1; t.cond = 3'd0;
        apply(t);
        tests++;
        if (CondExE !== 1'b0) begin
            fails++;
            $display("FAIL reset_eq_condex got=%b want=0", CondExE);
        end
        edge_wait();
        void'(sb.pop_front());
    endtask

    task automatic test_set_then_test();
        exp_t e;
        exp_t o;
        in_t  t;
        t = nop();
        t.valid = 1; t.cond = 3'd6; t.fw = 1; t.aflags = 2'b10;
        apply(t);
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || FlagsQ !== 2'b10) begin
            fails++;
            $display("FAIL set_flags got=%h want=%h", o, e);
        end
        t = nop();
        t.valid = 1; t.cond = 3'd0; t.rw = 1; t.res = 32'h0000_0005; t.rd = 4'd3;
        apply(t);
        tests++;
        if (CondExE !== 1'b1) begin
            fails++;
            $display("FAIL test_eq_condex got=%b want=1", CondExE);
        end
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || RegWriteM !== 1'b1 || ALUResultM !== 32'd5) begin
            fails++;
            $display("FAIL test_eq_result got=%h want=%h", o, e);
        end
    endtask

    task automatic test_cond_fail();
        exp_t e;
        exp_t o;
        in_t  t;
        t = nop();
        t.valid = 1; t.cond = 3'd6; t.fw = 1; t.aflags = 2'b00;
        apply(t);
        edge_wait();
        void'(sb.pop_front());
        t = nop();
        t.valid = 1; t.cond = 3'd2; t.mw = 1; t.fw = 1; t.aflags = 2'b01;
        t.res = 32'hdead_beef; t.wd = 32'h1234_5678;
        apply(t);
        tests++;
        if (CondExE !== 1'b0) begin
            fails++;
            $display("FAIL lt_fail_condex got=%b want=0", CondExE);
        end
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || MemWriteM !== 1'b0 || ValidM !== 1'b1 || FlagsQ !== 2'b00) begin
            fails++;
            $display("FAIL lt_fail_m got=%h want=%h", o, e);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        exp_t o;
        in_t  t;
        t = nop();
        t.valid = 1; t.cond = 3'd6; t.fw = 1; t.aflags = 2'b01; t.rw = 1;
        t.res = 32'h0000_00aa; t.rd = 4'd7; t.stall = 1;
        for (int i = 0; i < 3; i++) begin
            apply(t);
            edge_wait();
            e = sb.pop_front();
            o = sample();
            tests++;
            if (o !== e || FlagsQ !== 2'b00) begin
                fails++;
                $display("FAIL stall_hold[%0d] got=%h want=%h", i, o, e);
            end
        end
        t.stall = 0;
        apply(t);
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || FlagsQ !== 2'b01 || RegWriteM !== 1'b1) begin
            fails++;
            $display("FAIL stall_release got=%h want=%h", o, e);
        end
    endtask

    task automatic test_flush_stall();
        exp_t e;
        exp_t o;
        in_t  t;
        t = nop();
        t.valid = 1; t.cond = 3'd6; t.rw = 1; t.fw = 1; t.aflags = 2'b11;
        t.flush = 1; t.stall = 1;
        apply(t);
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if ({o.valid, o.rw, o.mw, o.m2r, o.pcs, o.flags} !==
            {e.valid, e.rw, e.mw, e.m2r, e.pcs, e.flags} || FlagsQ !== 2'b01) begin
            fails++;
            $display("FAIL flush_stall got=%h want=%h", o, e);
        end
    endtask

    task automatic test_bubble();
        exp_t e;
        exp_t o;
        in_t  t;
        t = nop();
        t.valid = 0; t.cond = 3'd6; t.fw = 1; t.aflags = 2'b10; t.rw = 1; t.pcs = 1;
        apply(t);
        tests++;
        if (CondExE !== 1'b0) begin
            fails++;
            $display("FAIL bubble_condex got=%b want=0", CondExE);
        end
        edge_wait();
        e = sb.pop_front();
        o = sample();
        tests++;
        if (o !== e || ValidM !== 1'b0 || PCSrcM !== 1'b0) begin
            fails++;
            $display("FAIL bubble_m got=%h want=%h", o, e);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        exp_t o;
        in_t  t;
        for (int f = 0; f < 4; f++) begin
            t = nop();
            t.valid = 1; t.cond = 3'd6; t.fw = 1; t.aflags = 2'(f);
            apply(t);
            edge_wait();
            void'(sb.pop_front());
            for (int c = 0; c < 8; c++) begin
                t = nop();
                t.valid = 1; t.cond = 3'(c); t.rw = 1; t.mw = 1; t.m2r = 1; t.pcs = 1;
                t.res = 32'(c * 16 + f); t.rd = 4'(c);
                apply(t);
                tests++;
                if (CondExE !== exp_cex) begin
                    fails++;
                    $display("FAIL sweep_condex cond=%0d flags=%0d got=%b want=%b",
                             c, f, CondExE, exp_cex);
                end
                edge_wait();
                e = sb.pop_front();
                o = sample();
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL sweep_m cond=%0d flags=%0d got=%h want=%h", c, f, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t o;
        in_t  t;
        for (int i = 0; i < 60; i++) begin
            t = rand_in();
            t.stall = ($urandom_range(0, 4) == 0);
            t.flush = ($urandom_range(0, 6) == 0);
            t.rst   = (i == 30);
            apply(t);
            tests++;
            if (CondExE !== exp_cex) begin
                fails++;
                $display("FAIL b2b_condex[%0d] got=%b want=%b", i, CondExE, exp_cex);
            end
            edge_wait();
            e = sb.pop_front();
            o = sample();
            if (!e.valid) begin
                o.res = '0; o.wd = '0; o.rd = '0;
                e.res = '0; e.wd = '0; e.rd = '0;
            end
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_m[%0d] got=%h want=%h", i, o, e);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m = '0;
        exp_cex = 1'b0;
        reset = 1'b1; StallE = 0; FlushE = 0; ValidE = 0; CondE = '0;
        FlagWriteE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
        ALUResultE = '0; ALUFlagsE = '0; WriteDataE = '0; RdE = '0;
        test_reset();
        test_set_then_test();
        test_cond_fail();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_sweep();
        test_back_to_back();
        test_reset();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
